// File: rtl/mac_pkg.sv
// Shared types for the mac window feeder: width defaults, feeder FSM states, column payloads.
package mac_pkg;

  localparam int unsigned IMG_W_DEF = 8;
  localparam int unsigned WGT_W_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } feed_state_e;

  // One column beat, row1 in the LSBs.
  typedef struct packed {
    logic [IMG_W_DEF-1:0] row3;
    logic [IMG_W_DEF-1:0] row2;
    logic [IMG_W_DEF-1:0] row1;
  } col_img_t;

  typedef struct packed {
    logic [WGT_W_DEF-1:0] row3;
    logic [WGT_W_DEF-1:0] row2;
    logic [WGT_W_DEF-1:0] row1;
  } col_wgt_t;

endpackage

// File: rtl/mac_row_shift3.sv
// Three-stage shift register with enable and synchronous clear; one window row.
module mac_row_shift3 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_old,
  output logic [W-1:0] o_mid,
  output logic [W-1:0] o_new
);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      o_old <= '0;
      o_mid <= '0;
      o_new <= '0;
    end else if (i_clr) begin
      o_old <= '0;
      o_mid <= '0;
      o_new <= '0;
    end else if (i_en) begin
      o_old <= o_mid;
      o_mid <= o_new;
      o_new <= i_d;
    end
  end

endmodule

// File: rtl/mac_window_feeder.sv
// Column-stream to 3x3 sliding window feeder driving the mac window inputs.
module mac_window_feeder
  import mac_pkg::*;
#(
  parameter int unsigned COLS  = 128,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned WGT_W = WGT_W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_hold,
  input  logic               i_col_valid,
  output logic               i_col_ready,
  input  logic [3*IMG_W-1:0] i_col_img,
  input  logic [3*WGT_W-1:0] i_col_wgt,
  input  logic               i_col_last,
  output logic [IMG_W-1:0]   o_im1,
  output logic [IMG_W-1:0]   o_im2,
  output logic [IMG_W-1:0]   o_im3,
  output logic [IMG_W-1:0]   o_im4,
  output logic [IMG_W-1:0]   o_im5,
  output logic [IMG_W-1:0]   o_im6,
  output logic [IMG_W-1:0]   o_im7,
  output logic [IMG_W-1:0]   o_im8,
  output logic [IMG_W-1:0]   o_im9,
  output logic [WGT_W-1:0]   o_ker1,
  output logic [WGT_W-1:0]   o_ker2,
  output logic [WGT_W-1:0]   o_ker3,
  output logic [WGT_W-1:0]   o_ker4,
  output logic [WGT_W-1:0]   o_ker5,
  output logic [WGT_W-1:0]   o_ker6,
  output logic [WGT_W-1:0]   o_ker7,
  output logic [WGT_W-1:0]   o_ker8,
  output logic [WGT_W-1:0]   o_ker9,
  output logic               o_valid,
  output logic               o_stripe_done,
  output logic [CNT_W-1:0]   o_win_cnt,
  output logic               o_len_err
);

  localparam int unsigned CC_W = $clog2(COLS + 1);

  feed_state_e       state_q, state_d;
  logic [CC_W-1:0]   col_cnt_q, col_cnt_d, col_inc;
  logic [CNT_W-1:0]  win_cnt_d;
  logic              valid_d, done_d, err_d;
  logic              accept, at_max, stripe_end;

  logic [IMG_W-1:0]  im_q  [3][3];
  logic [WGT_W-1:0]  ker_q [3][3];

  assign i_col_ready = ~i_hold & ~i_rst;
  assign accept      = i_col_valid & i_col_ready;

  // [row][age]: age 0 is the oldest column, age 2 the newest.
  for (genvar r = 0; r < 3; r++) begin : g_row
    mac_row_shift3 #(.W(IMG_W)) u_im (
      .clk   (clk),
      .i_rst (i_rst),
      .i_clr (i_clear),
      .i_en  (accept),
      .i_d   (i_col_img[r*IMG_W +: IMG_W]),
      .o_old (im_q[r][0]),
      .o_mid (im_q[r][1]),
      .o_new (im_q[r][2])
    );
    mac_row_shift3 #(.W(WGT_W)) u_ker (
      .clk   (clk),
      .i_rst (i_rst),
      .i_clr (i_clear),
      .i_en  (accept),
      .i_d   (i_col_wgt[r*WGT_W +: WGT_W]),
      .o_old (ker_q[r][0]),
      .o_mid (ker_q[r][1]),
      .o_new (ker_q[r][2])
    );
  end

  assign o_im1  = im_q[0][0];
  assign o_im2  = im_q[0][1];
  assign o_im3  = im_q[0][2];
  assign o_im4  = im_q[1][0];
  assign o_im5  = im_q[1][1];
  assign o_im6  = im_q[1][2];
  assign o_im7  = im_q[2][0];
  assign o_im8  = im_q[2][1];
  assign o_im9  = im_q[2][2];
  assign o_ker1 = ker_q[0][0];
  assign o_ker2 = ker_q[0][1];
  assign o_ker3 = ker_q[0][2];
  assign o_ker4 = ker_q[1][0];
  assign o_ker5 = ker_q[1][1];
  assign o_ker6 = ker_q[1][2];
  assign o_ker7 = ker_q[2][0];
  assign o_ker8 = ker_q[2][1];
  assign o_ker9 = ker_q[2][2];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= EMPTY;
      col_cnt_q     <= '0;
      o_valid       <= 1'b0;
      o_stripe_done <= 1'b0;
      o_win_cnt     <= '0;
      o_len_err     <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      o_valid       <= valid_d;
      o_stripe_done <= done_d;
      o_win_cnt     <= win_cnt_d;
      o_len_err     <= err_d;
    end
  end

  // A stripe ends on last or when the column count reaches COLS; a mismatch of the two is a length error.
  always_comb begin
    state_d    = state_q;
    col_cnt_d  = col_cnt_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = o_len_err;
    win_cnt_d  = o_win_cnt;
    col_inc    = col_cnt_q + CC_W'(1);
    at_max     = (col_inc == CC_W'(COLS));
    stripe_end = i_col_last | at_max;

    if (i_clear) begin
      state_d   = EMPTY;
      col_cnt_d = '0;
      err_d     = 1'b0;
      win_cnt_d = '0;
    end else if (accept) begin
      valid_d = (state_q == TWO) || (state_q == FULL);
      if (valid_d) begin
        win_cnt_d = o_win_cnt + CNT_W'(1);
      end
      if (i_col_last != at_max) begin
        err_d = 1'b1;
      end
      if (stripe_end) begin
        state_d   = EMPTY;
        col_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        col_cnt_d = col_inc;
        case (state_q)
          EMPTY:   state_d = ONE;
          ONE:     state_d = TWO;
          default: state_d = FULL;
        endcase
      end
    end
  end

endmodule
